// File: rtl/window_generator_pkg.sv
// Shared image-pipeline types and default geometry for the 3x3 window generator.
// Optional start-of-frame resync is controlled by WINDOW_GEN_SOF_EN.
package img_pkg;

    localparam int unsigned PIX_W          = 16;
    localparam int unsigned DEF_IMG_WIDTH  = 640;
    localparam int unsigned DEF_IMG_HEIGHT = 480;

    localparam int unsigned COL_W = $clog2(DEF_IMG_WIDTH);
    localparam int unsigned ROW_W = $clog2(DEF_IMG_HEIGHT);

    typedef logic [15:0]      pixel_t;
    typedef pixel_t [8:0]     window_t;
    typedef logic [COL_W-1:0] col_t;
    typedef logic [ROW_W-1:0] row_t;

endpackage

// File: rtl/window_generator_if.sv
// Pixel stream in / 3x3 window out bundle for window_generator.
// The sof signal exists only when WINDOW_GEN_SOF_EN is defined.
interface window_generator_if #(
    parameter int unsigned PIX_W = img_pkg::PIX_W
);
    logic [PIX_W-1:0]      pixel_in;
    logic                  pixel_valid;
`ifdef WINDOW_GEN_SOF_EN
    logic                  sof;
`endif
    logic [8:0][PIX_W-1:0] pixel_buffer;
    logic                  valid_buffer;
    logic                  win_last;

`ifdef WINDOW_GEN_SOF_EN
    modport master (output pixel_in, pixel_valid, sof,
                    input  pixel_buffer, valid_buffer, win_last);
    modport slave  (input  pixel_in, pixel_valid, sof,
                    output pixel_buffer, valid_buffer, win_last);
`else
    modport master (output pixel_in, pixel_valid,
                    input  pixel_buffer, valid_buffer, win_last);
    modport slave  (input  pixel_in, pixel_valid,
                    output pixel_buffer, valid_buffer, win_last);
`endif

endinterface

// File: rtl/window_generator_line_buffer.sv
// Single-port line store: combinational read, synchronous write, no reset.
// Reading and writing the same address in one cycle returns the old contents.
module line_buffer #(
    parameter int unsigned DEPTH = 640,
    parameter int unsigned WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/window_generator.sv
// Streaming 3x3 sliding-window generator over a raster pixel stream.
// Define WINDOW_GEN_SOF_EN to add the sof resync input.
module window_generator
    import img_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int unsigned PIX_W      = img_pkg::PIX_W
) (
    input  logic               clk,
    input  logic               reset_n,
    window_generator_if.slave  bus
);

    localparam int unsigned CW = $clog2(IMG_WIDTH);
    localparam int unsigned RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0]         col, cur_col;
    logic [RW-1:0]         row, cur_row;
    logic [PIX_W-1:0]      a, b;
    logic [8:0][PIX_W-1:0] win;
    logic                  valid_q, last_q;
    logic                  interior, col_last, row_last;

    // Position of the pixel being accepted this cycle (sof forces it to the origin)
    always_comb begin
        cur_col = col;
        cur_row = row;
`ifdef WINDOW_GEN_SOF_EN
        if (bus.sof) begin
            cur_col = '0;
            cur_row = '0;
        end
`endif
    end

    assign col_last = (cur_col == COL_LAST);
    assign row_last = (cur_row == ROW_LAST);
    assign interior = (cur_row >= RW'(2)) && (cur_col >= CW'(2));

    // lb_a holds row r-1, lb_b holds row r-2; lb_b is fed from lb_a's old contents
    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) lb_a (
        .clk   (clk),
        .we    (bus.pixel_valid),
        .addr  (cur_col),
        .wdata (bus.pixel_in),
        .rdata (a)
    );

    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) lb_b (
        .clk   (clk),
        .we    (bus.pixel_valid),
        .addr  (cur_col),
        .wdata (a),
        .rdata (b)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col     <= '0;
            row     <= '0;
            win     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= bus.pixel_valid && interior;
            last_q  <= bus.pixel_valid && interior && row_last && col_last;
            if (bus.pixel_valid) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : cur_row + RW'(1);
                end else begin
                    col <= cur_col + CW'(1);
                    row <= cur_row;
                end
                win[0] <= win[1];
                win[1] <= win[2];
                win[2] <= b;
                win[3] <= win[4];
                win[4] <= win[5];
                win[5] <= a;
                win[6] <= win[7];
                win[7] <= win[8];
                win[8] <= bus.pixel_in;
            end
        end
    end

    assign bus.pixel_buffer = win;
    assign bus.valid_buffer = valid_q;
    assign bus.win_last     = last_q;

endmodule

// File: tb/tb_window_generator.sv
// Scoreboard bench for window_generator on a 4x4 image.
// The sof resync scenario runs only when WINDOW_GEN_SOF_EN is defined.
module tb_window_generator;
    import img_pkg::*;

    localparam int unsigned W = 4;
    localparam int unsigned H = 4;

    typedef struct {
        window_t win;
        logic    last;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic prev_acc = 1'b0;
    exp_t exp_q[$];

    // Hand-computed windows of a 4x4 frame holding pixels 0..15 in raster order
    int base_tbl [4][9] = '{
        '{0, 1, 2, 4, 5, 6,  8,  9, 10},
        '{1, 2, 3, 5, 6, 7,  9, 10, 11},
        '{4, 5, 6, 8, 9, 10, 12, 13, 14},
        '{5, 6, 7, 9, 10, 11, 13, 14, 15}
    };

    window_generator_if #(.PIX_W(16)) bus ();

    window_generator #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .PIX_W      (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) prev_acc <= bus.pixel_valid && reset_n;

    always @(negedge clk) begin
        if (reset_n && bus.win_last && !bus.valid_buffer) begin
            checks++;
            failures++;
            $display("FAIL last_without_valid: win_last=1 valid_buffer=0");
        end
        if (reset_n && bus.valid_buffer) begin
            checks++;
            if (!prev_acc) begin
                failures++;
                $display("FAIL gap_valid: valid_buffer=1 after a cycle with no accepted pixel");
            end
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_window: got %h, required no window", bus.pixel_buffer);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.pixel_buffer !== e.win) begin
                    failures++;
                    $display("FAIL window: got %h required %h", bus.pixel_buffer, e.win);
                end
                checks++;
                if (bus.win_last !== e.last) begin
                    failures++;
                    $display("FAIL win_last: got %b required %b", bus.win_last, e.last);
                end
            end
        end
    end

    task automatic push_frame(input int off);
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            for (int k = 0; k < 9; k++) e.win[k] = pixel_t'(base_tbl[i][k] + off);
            e.last = (i == 3);
            exp_q.push_back(e);
        end
    endtask

    task automatic send(input int p, input logic s);
        @(negedge clk);
        bus.pixel_valid = 1'b1;
        bus.pixel_in    = pixel_t'(p);
`ifdef WINDOW_GEN_SOF_EN
        bus.sof         = s;
`else
        if (s) $display("sof requested without WINDOW_GEN_SOF_EN");
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.pixel_valid = 1'b0;
            bus.pixel_in    = pixel_t'($urandom);
`ifdef WINDOW_GEN_SOF_EN
            bus.sof         = 1'b0;
`endif
        end
    endtask

    task automatic frame(input int off, input bit gaps, input bit with_sof);
        push_frame(off);
        for (int p = 0; p < 16; p++) begin
            send(off + p, with_sof && (p == 0));
            if (gaps) idle($urandom_range(0, 2));
        end
        idle(3);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (bus.valid_buffer !== 1'b0 || bus.win_last !== 1'b0 || bus.pixel_buffer !== '0) begin
            failures++;
            $display("FAIL %s: valid=%b last=%b win=%h, required 0/0/0",
                     tag, bus.valid_buffer, bus.win_last, bus.pixel_buffer);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        bus.pixel_valid = 1'b0;
        bus.pixel_in    = '0;
`ifdef WINDOW_GEN_SOF_EN
        bus.sof         = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_state");
        reset_n = 1'b1;

        // Back-to-back frame
        frame(0, 1'b0, 1'b0);
        // Same frame with idle gaps
        frame(0, 1'b1, 1'b0);
        // Two consecutive frames, second offset by 100
        frame(0, 1'b0, 1'b0);
        frame(100, 1'b0, 1'b0);

        // Reset mid-frame after six pixels
        for (int p = 0; p < 6; p++) send(200 + p, 1'b0);
        @(negedge clk);
        bus.pixel_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("reset_async");
        @(negedge clk);
        check_reset_outputs("reset_hold");
        reset_n = 1'b1;
        frame(0, 1'b0, 1'b0);

`ifdef WINDOW_GEN_SOF_EN
        for (int p = 0; p < 5; p++) send(300 + p, 1'b0);
        frame(0, 1'b0, 1'b1);
`endif

        idle(5);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d windows outstanding, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
